// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Define DIV_UNIT_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic            neg_q, neg_r, rem_sel;

  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, ovf, early, bypass, accept;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] fin_q, fin_r;

  assign sgn      = ~op[0];
  assign a_neg    = sgn & dividend[XLEN-1];
  assign b_neg    = sgn & divisor[XLEN-1];
  assign abs_a    = a_neg ? -dividend : dividend;
  assign abs_b    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn
                  && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  && (&divisor);

`ifdef DIV_UNIT_EARLY_OUT_EN
  assign early = !div_zero && (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  assign bypass = div_zero | ovf | early;
  assign accept = (state == IDLE) && start && !kill;

  // MSB of the widened trial difference set means "does not fit": restore
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign fin_q = neg_q ? -quo : quo;
  assign fin_r = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    if (start) state_nxt = bypass ? FINISH : CALC;
      CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        rem_sel <= op[1];
        dvs     <= abs_b;
        neg_q   <= 1'b0;
        neg_r   <= 1'b0;
        if (div_zero) begin
          quo <= '1;
          rem <= dividend;
        end else if (ovf) begin
          quo <= dividend;
          rem <= '0;
        end else if (early) begin
          quo <= '0;
          rem <= dividend;
        end else begin
          quo   <= abs_a;
          rem   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (!kill && state == CALC) begin
        rem <= trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]}
                           : trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ~trial[XLEN]};
        cnt <= cnt + 1'b1;
      end else if (!kill && state == FINISH) begin
        result <= rem_sel ? fin_r : fin_q;
        done   <= 1'b1;
      end
    end
  end

endmodule
